// File: rtl/buffer_loader_pkg.sv
// Shared definitions for the byte-to-word buffer loader and the 8x16 buffer it fills.
package buffer_loader_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned COUNT_W = 4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    ST_HI   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/buffer_loader_if.sv
// Bundle of the loader's upstream handshake and buffer-side signals.
interface buffer_loader_if;
  import buffer_loader_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [BYTE_W-1:0]     in_byte;
  logic                  in_last;
  logic                  done_ack;
  logic                  write;
  logic [ADDR_W-1:0]     Addr;
  logic [DATA_W-1:0]     wData;
  logic                  frame_done;
  logic [COUNT_W-1:0]    word_count;

  // Producer/consumer side of the loader.
  modport master (
    output in_valid, in_byte, in_last, done_ack,
    input  in_ready, write, Addr, wData, frame_done, word_count
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_byte, in_last, done_ack,
    output in_ready, write, Addr, wData, frame_done, word_count
  );
endinterface

// File: rtl/buffer.sv
// 8x16 word buffer written by buffer_loader; asynchronous read port for the consumer.
module buffer
  import buffer_loader_pkg::*;
(
  input  logic              clk,
  input  logic              write,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write) mem[Addr] <= wData;
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/buffer_loader.sv
// Packs an upstream byte stream into 16-bit words (low byte first) and writes
// up to eight words per frame into the buffer, holding the frame until acknowledged.
module buffer_loader
  import buffer_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BYTE_W-1:0]  in_byte,
  input  logic               in_last,
  input  logic               done_ack,
  output logic               write,
  output logic [ADDR_W-1:0]  Addr,
  output logic [DATA_W-1:0]  wData,
  output logic               frame_done,
  output logic [COUNT_W-1:0] word_count
);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   ptr, ptr_d;
  logic [BYTE_W-1:0]   low, low_d;
  logic                write_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [COUNT_W-1:0]  count_d;
  logic                do_write;
  logic [DATA_W-1:0]   word;

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    low_d    = low;
    write_d  = 1'b0;
    addr_d   = Addr;
    wdata_d  = wData;
    count_d  = word_count;
    do_write = 1'b0;
    word     = '0;

    unique case (state)
      ST_LO: begin
        if (in_valid) begin
          if (in_last) begin
            do_write = 1'b1;
            word     = {PAD_BYTE, in_byte};
          end else begin
            low_d   = in_byte;
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (in_valid) begin
          do_write = 1'b1;
          word     = {in_byte, low};
        end
      end
      ST_DONE: begin
        if (done_ack) begin
          state_d = ST_LO;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = ST_LO;
    endcase

    // Shared word-commit path for both the padded single byte and the byte pair.
    if (do_write) begin
      write_d = 1'b1;
      addr_d  = ptr;
      wdata_d = word;
      ptr_d   = ptr + 1'b1;
      count_d = word_count + 1'b1;
      state_d = (in_last || ptr == LAST_ADDR) ? ST_DONE : ST_LO;
    end

    in_ready   = (state != ST_DONE);
    frame_done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LO;
      ptr        <= '0;
      low        <= '0;
      write      <= 1'b0;
      Addr       <= '0;
      wData      <= '0;
      word_count <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      low        <= low_d;
      write      <= write_d;
      Addr       <= addr_d;
      wData      <= wdata_d;
      word_count <= count_d;
    end
  end

endmodule

// File: tb/tb_buffer_loader.sv
// Randomized self-checking bench for buffer_loader against a frame-level byte-pairing model.
module tb_buffer_loader;
  import buffer_loader_pkg::*;

  localparam logic [7:0] PAD = 8'h00;

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  buffer_loader_if bus ();

  buffer_loader #(.PAD_BYTE(PAD)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (bus.in_valid),
    .in_ready   (bus.in_ready),
    .in_byte    (bus.in_byte),
    .in_last    (bus.in_last),
    .done_ack   (bus.done_ack),
    .write      (bus.write),
    .Addr       (bus.Addr),
    .wData      (bus.wData),
    .frame_done (bus.frame_done),
    .word_count (bus.word_count)
  );

  buffer u_buf (
    .clk   (clk),
    .write (bus.write),
    .Addr  (bus.Addr),
    .wData (bus.wData),
    .rAddr (rd_addr),
    .rData (rd_data)
  );

  always #5 clk = ~clk;

  int         exp_addr[$];
  logic [15:0] exp_data[$];
  int         obs_addr[$];
  logic [15:0] obs_data[$];
  logic [7:0] frame[$];

  always @(negedge clk) begin
    if (!reset && bus.write) begin
      obs_addr.push_back(int'(bus.Addr));
      obs_data.push_back(bus.wData);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
    bit acc;
    int g;
    g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = bus.in_ready;
      tick();
    end
    if (!acc) check_eq("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Expected words for the bytes in `frame`: pairs low-then-high, odd tail padded.
  task automatic model_frame();
    int n;
    logic [7:0] lo, hi;
    n = frame.size();
    for (int w = 0; w < (n + 1) / 2; w++) begin
      lo = frame[2*w];
      hi = (2*w + 1 < n) ? frame[2*w+1] : PAD;
      exp_addr.push_back(w);
      exp_data.push_back({hi, lo});
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    tick();
    check_eq({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_addr"}, obs_addr[i], exp_addr[i]);
      check_eq({tag, "_data"}, obs_data[i], exp_data[i]);
      rd_addr = exp_addr[i][ADDR_W-1:0];
      #1;
      check_eq({tag, "_bufmem"}, rd_data, exp_data[i]);
    end
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic send_frame(input string tag, input bit last_on_end, input bit gaps);
    int n;
    n = frame.size();
    for (int i = 0; i < n; i++) send_byte(frame[i], (i == n - 1) && last_on_end, gaps);
    model_frame();
    check_eq({tag, "_write_pulse"}, bus.write, 1);
    check_eq({tag, "_frame_done"}, bus.frame_done, 1);
    check_eq({tag, "_word_count"}, bus.word_count, (n + 1) / 2);
    compare_writes(tag);
  endtask

  task automatic ack();
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    bus.in_last  = 1'b0;
    bus.done_ack = 1'b0;
    rd_addr      = '0;
    reset        = 1'b1;
    repeat (3) tick();
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_write", bus.write, 0);
    check_eq("rst_addr", bus.Addr, 0);
    check_eq("rst_wdata", bus.wData, 0);
    check_eq("rst_frame_done", bus.frame_done, 0);
    check_eq("rst_word_count", bus.word_count, 0);
    reset = 1'b0;
    tick();

    // Full 16-byte frame 0x01..0x10.
    frame.delete();
    for (int i = 1; i <= 16; i++) frame.push_back(8'(i));
    send_frame("full", 1'b1, 1'b1);

    // Backpressure while the frame is held.
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    check_eq("bp_no_writes", obs_addr.size(), 0);
    check_eq("bp_word_count", bus.word_count, 8);
    ack();
    check_eq("ack_frame_done", bus.frame_done, 0);
    check_eq("ack_word_count", bus.word_count, 0);
    check_eq("ack_in_ready", bus.in_ready, 1);

    // Odd short frame with padding.
    frame.delete();
    frame.push_back(8'hAA); frame.push_back(8'hBB); frame.push_back(8'hCC);
    send_frame("odd", 1'b1, 1'b0);
    ack();

    // Reset after a latched low byte discards it.
    send_byte(8'h55, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_eq("midrst_write", bus.write, 0);
    check_eq("midrst_word_count", bus.word_count, 0);
    reset = 1'b0;
    frame.delete();
    frame.push_back(8'h11); frame.push_back(8'h22);
    send_frame("midrst", 1'b1, 1'b0);
    ack();

    // Stray acknowledge mid-frame.
    frame.delete();
    for (int i = 0; i < 8; i++) frame.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) send_byte(frame[i], 1'b0, 1'b1);
    check_eq("stray_count_before", bus.word_count, 3);
    ack();
    check_eq("stray_count_after", bus.word_count, 3);
    check_eq("stray_frame_done", bus.frame_done, 0);
    check_eq("stray_in_ready", bus.in_ready, 1);
    send_byte(frame[6], 1'b0, 1'b1);
    send_byte(frame[7], 1'b1, 1'b1);
    model_frame();
    check_eq("stray_final_count", bus.word_count, 4);
    check_eq("stray_final_done", bus.frame_done, 1);
    compare_writes("stray");
    ack();

    // Random frames, including full frames closed by depth rather than in_last.
    for (int f = 0; f < 25; f++) begin
      int n;
      bit lastf;
      n = $urandom_range(1, 16);
      lastf = (n == 16) ? 1'($urandom) : 1'b1;
      frame.delete();
      for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
      send_frame("rand", lastf, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'($urandom);
        tick();
      end
      bus.in_valid = 1'b0;
      check_eq("rand_hold_done", bus.frame_done, 1);
      ack();
      check_eq("rand_ack_count", bus.word_count, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
